// File: rtl/if_stage_pkg.sv
// ============================================================================
// Module   : if_stage_pkg
// Purpose  : Shared constants for the fetch stage and its neighbours.
// Revision : 1.0
// ============================================================================
`default_nettype none

package if_stage_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_FETCH = 2'd0;
    localparam state_t ST_HOLD  = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;

    // Execute decodes these to raise Redirect.
    localparam logic [5:0] OP_JMP = 6'b100010;
    localparam logic [5:0] OP_JB  = 6'b100011;

endpackage

`default_nettype wire

// File: rtl/if_stage_if.sv
// ============================================================================
// Module   : if_stage_if
// Purpose  : Instruction-memory req/ack bus between fetch and memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface if_stage_if #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
);
    logic               IMemReq;
    logic [PC_W-1:0]    IMemAddr;
    logic               IMemAck;
    logic [INSTR_W-1:0] IMemData;

    modport master (
        output IMemReq,
        output IMemAddr,
        input  IMemAck,
        input  IMemData
    );

    modport slave (
        input  IMemReq,
        input  IMemAddr,
        output IMemAck,
        output IMemData
    );
endinterface

`default_nettype wire

// File: rtl/if_stage_if_id_reg.sv
// ============================================================================
// Module   : if_id_reg
// Purpose  : Pipeline register with flush > load > hold > bubble priority.
// Revision : 1.0
// ============================================================================
`default_nettype none

module if_id_reg #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               flush_i,
    input  wire logic               load_i,
    input  wire logic               hold_i,
    input  wire logic [INSTR_W-1:0] instr_i,
    input  wire logic [PC_W-1:0]    pc_i,
    output logic                    valid_o,
    output logic [INSTR_W-1:0]      instr_o,
    output logic [PC_W-1:0]         pc_o
);

    logic               valid_q;
    logic [INSTR_W-1:0] instr_q;
    logic [PC_W-1:0]    pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end else if (!hold_i) begin
            // Consumed with nothing to replace it: leave a bubble.
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// Module   : if_stage
// Purpose  : PC, single-outstanding fetch FSM, skid buffer and IF/ID register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module if_stage
    import if_stage_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter int              INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int unsigned     PC_STEP  = 4
) (
    input  wire logic               CLK,
    input  wire logic               Reset,
    if_stage_if.master              imem,
    input  wire logic               Stall,
    input  wire logic               Redirect,
    input  wire logic [PC_W-1:0]    RedirectPC,
    output logic                    InstrValid,
    output logic [INSTR_W-1:0]      Instr,
    output logic [5:0]              OpCode,
    output logic [PC_W-1:0]         InstrPC
);

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    target_q, target_d;
    logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;

    logic               w_ack;
    logic               w_accept;
    logic               w_load;
    logic [INSTR_W-1:0] w_load_instr;
    logic [PC_W-1:0]    w_load_pc;
    logic [PC_W-1:0]    w_pc_inc;

    // DRAIN keeps the request up on the old PC: an issued fetch cannot be withdrawn.
    assign imem.IMemReq  = !Reset && (state_q != ST_HOLD);
    assign imem.IMemAddr = pc_q;

    assign w_ack    = imem.IMemAck && imem.IMemReq;
    assign w_accept = !Stall || !InstrValid;
    assign w_pc_inc = pc_q + PC_W'(PC_STEP);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        target_d     = target_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        w_load       = 1'b0;
        w_load_instr = imem.IMemData;
        w_load_pc    = pc_q;

        case (state_q)
            ST_FETCH: begin
                if (w_ack) begin
                    if (Redirect) begin
                        pc_d = RedirectPC;
                    end else if (w_accept) begin
                        w_load = 1'b1;
                        pc_d   = w_pc_inc;
                    end else begin
                        skid_instr_d = imem.IMemData;
                        skid_pc_d    = pc_q;
                        pc_d         = w_pc_inc;
                        state_d      = ST_HOLD;
                    end
                end else if (Redirect) begin
                    target_d = RedirectPC;
                    state_d  = ST_DRAIN;
                end
            end
            ST_HOLD: begin
                if (Redirect) begin
                    pc_d    = RedirectPC;
                    state_d = ST_FETCH;
                end else if (w_accept) begin
                    w_load       = 1'b1;
                    w_load_instr = skid_instr_q;
                    w_load_pc    = skid_pc_q;
                    state_d      = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (Redirect) begin
                    target_d = RedirectPC;
                end
                if (w_ack) begin
                    pc_d    = Redirect ? RedirectPC : target_q;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            target_q     <= '0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            target_q     <= target_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
        end
    end

    if_id_reg #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_if_id (
        .clk     (CLK),
        .rst     (Reset),
        .flush_i (Redirect),
        .load_i  (w_load),
        .hold_i  (!w_accept),
        .instr_i (w_load_instr),
        .pc_i    (w_load_pc),
        .valid_o (InstrValid),
        .instr_o (Instr),
        .pc_o    (InstrPC)
    );

    assign OpCode = Instr[OPCODE_MSB:OPCODE_LSB];

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// Module   : tb_if_stage
// Purpose  : Directed scenarios plus random traffic against a behavioural model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'h0;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        Stall;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        InstrValid;
    logic [31:0] Instr;
    logic [5:0]  OpCode;
    logic [31:0] InstrPC;

    if_stage_if #(.PC_W(32), .INSTR_W(32)) imem_bus ();

    if_stage #(
        .PC_W     (32),
        .INSTR_W  (32),
        .RESET_PC (RST_PC),
        .PC_STEP  (4)
    ) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .imem       (imem_bus),
        .Stall      (Stall),
        .Redirect   (Redirect),
        .RedirectPC (RedirectPC),
        .InstrValid (InstrValid),
        .Instr      (Instr),
        .OpCode     (OpCode),
        .InstrPC    (InstrPC)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: PC, a pending-discard flag, a one-word skid slot, IF/ID.
    logic [31:0] m_pc, m_target, m_skid_instr, m_skid_pc, m_instr, m_ipc;
    bit          m_stale, m_skid_full, m_v;
    bit          ovr_en = 1'b0;
    logic [31:0] ovr_data = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a | 32'h0400_0000;
    endfunction

    task automatic model_reset();
        m_pc = RST_PC; m_target = '0; m_skid_instr = '0; m_skid_pc = '0;
        m_instr = '0; m_ipc = '0; m_stale = 0; m_skid_full = 0; m_v = 0;
    endtask

    task automatic cycle(input bit rst, input bit stall, input bit redir,
                         input logic [31:0] rpc, input bit ack);
        logic [31:0] data, d_instr, d_pc;
        bit req, acc, take, dlv;
        data = ovr_en ? ovr_data : mem_word(m_pc);
        Reset = rst; Stall = stall; Redirect = redir; RedirectPC = rpc;
        imem_bus.IMemAck = ack; imem_bus.IMemData = data;
        #1;
        req = !rst && !m_skid_full;
        check_val("req", {31'b0, imem_bus.IMemReq}, {31'b0, req});
        if (req) check_val("addr", imem_bus.IMemAddr, m_pc);
        check_val("valid", {31'b0, InstrValid}, {31'b0, m_v});
        if (m_v) begin
            check_val("instr", Instr, m_instr);
            check_val("ipc", InstrPC, m_ipc);
            check_val("opcode", {26'b0, OpCode}, {26'b0, m_instr[31:26]});
        end
        if (rst) begin
            model_reset();
        end else begin
            take = ack && req;
            acc  = !stall || !m_v;
            dlv  = 0; d_instr = '0; d_pc = '0;
            if (m_skid_full) begin
                if (redir) begin
                    m_skid_full = 0; m_pc = rpc;
                end else if (acc) begin
                    dlv = 1; d_instr = m_skid_instr; d_pc = m_skid_pc; m_skid_full = 0;
                end
            end else if (m_stale) begin
                if (redir) m_target = rpc;
                if (take) begin m_pc = m_target; m_stale = 0; end
            end else if (take) begin
                if (redir) begin
                    m_pc = rpc;
                end else begin
                    if (acc) begin
                        dlv = 1; d_instr = data; d_pc = m_pc;
                    end else begin
                        m_skid_full = 1; m_skid_instr = data; m_skid_pc = m_pc;
                    end
                    m_pc = m_pc + 32'd4;
                end
            end else if (redir) begin
                m_stale = 1; m_target = rpc;
            end
            if (redir)     m_v = 0;
            else if (dlv)  begin m_v = 1; m_instr = d_instr; m_ipc = d_pc; end
            else if (acc)  m_v = 0;
        end
        @(negedge CLK);
    endtask

    initial begin
        Reset = 1'b1; Stall = 1'b0; Redirect = 1'b0; RedirectPC = '0;
        imem_bus.IMemAck = 1'b0; imem_bus.IMemData = '0;
        model_reset();
        @(negedge CLK);

        // Reset then free-run with ack every cycle.
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        check_val("rst_valid", {31'b0, InstrValid}, 32'd0);
        check_val("rst_instr", Instr, 32'd0);
        check_val("rst_ipc", InstrPC, 32'd0);
        check_val("rst_req", {31'b0, imem_bus.IMemReq}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            cycle(0, 0, 0, 0, 1);
            check_val("run_ipc", InstrPC, 32'(4 * k));
            check_val("run_op", {26'b0, OpCode}, 32'd1);
            check_val("run_valid", {31'b0, InstrValid}, 32'd1);
        end

        // Redirect while the fetch of 0x20 is still waiting for its ack.
        cycle(0, 0, 1, 32'h100, 0);
        check_val("drain_addr", imem_bus.IMemAddr, 32'h20);
        check_val("drain_valid", {31'b0, InstrValid}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            cycle(0, 0, 0, 0, 0);
            check_val("drain_addr", imem_bus.IMemAddr, 32'h20);
            check_val("drain_req", {31'b0, imem_bus.IMemReq}, 32'd1);
            check_val("drain_valid", {31'b0, InstrValid}, 32'd0);
        end
        cycle(0, 0, 0, 0, 1);
        check_val("drain_tgt", imem_bus.IMemAddr, 32'h100);
        check_val("drain_drop", {31'b0, InstrValid}, 32'd0);

        // Redirect, stall and ack all in one cycle.
        cycle(0, 0, 0, 0, 1);
        check_val("tgt_ipc", InstrPC, 32'h100);
        cycle(0, 1, 1, 32'h200, 1);
        check_val("rsa_valid", {31'b0, InstrValid}, 32'd0);
        check_val("rsa_req", {31'b0, imem_bus.IMemReq}, 32'd1);
        check_val("rsa_addr", imem_bus.IMemAddr, 32'h200);

        // PC wrap.
        cycle(0, 0, 1, 32'hFFFF_FFFC, 1);
        check_val("wrap_addr0", imem_bus.IMemAddr, 32'hFFFF_FFFC);
        cycle(0, 0, 0, 0, 1);
        check_val("wrap_ipc", InstrPC, 32'hFFFF_FFFC);
        check_val("wrap_addr1", imem_bus.IMemAddr, 32'h0);

        // Stall in the ack cycle goes through the skid buffer.
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        ovr_en = 1'b1; ovr_data = 32'h8800_0010;
        cycle(0, 1, 0, 0, 1);
        ovr_en = 1'b0;
        check_val("hold_req", {31'b0, imem_bus.IMemReq}, 32'd0);
        check_val("hold_ipc", InstrPC, 32'h4);
        for (int k = 0; k < 2; k++) begin
            cycle(0, 1, 0, 0, 0);
            check_val("hold_req", {31'b0, imem_bus.IMemReq}, 32'd0);
            check_val("hold_ipc", InstrPC, 32'h4);
        end
        cycle(0, 0, 0, 0, 0);
        check_val("skid_instr", Instr, 32'h8800_0010);
        check_val("skid_ipc", InstrPC, 32'h8);
        check_val("skid_op", {26'b0, OpCode}, 32'h22);
        check_val("skid_next", imem_bus.IMemAddr, 32'hC);

        // Reset while holding a skid entry.
        cycle(0, 1, 0, 0, 1);
        check_val("hold2_req", {31'b0, imem_bus.IMemReq}, 32'd0);
        cycle(1, 1, 0, 0, 0);
        check_val("rhold_valid", {31'b0, InstrValid}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 0, 0, 0);
            check_val("rhold_valid", {31'b0, InstrValid}, 32'd0);
            check_val("rhold_addr", imem_bus.IMemAddr, RST_PC);
        end

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            bit r_rst, r_stall, r_redir, r_ack;
            logic [31:0] r_pc;
            r_rst   = ($urandom_range(0, 199) == 0);
            r_stall = ($urandom_range(0, 99) < 30);
            r_redir = ($urandom_range(0, 99) < 8);
            r_ack   = ($urandom_range(0, 99) < 60);
            r_pc    = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_0FFC);
            cycle(r_rst, r_stall, r_redir, r_pc, r_ack);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/if_stage.md
# if_stage

Instruction fetch stage directly upstream of the control unit. Holds the PC, issues one-outstanding-request fetches to instruction memory over a req/ack handshake, and delivers fetched words through an IF/ID pipeline register whose `Instr[31:26]` drives the control unit's `OpCode`. It supports hazard stall, a one-entry skid buffer, and jmp/jb redirect from the execute stage with safe discard of an in-flight fetch.

## Interface
- `PC_W`, default 32: PC and address width.
- `INSTR_W`, default 32: instruction width; must be ≥ 32.
- `RESET_PC`, default 0: PC value loaded on reset.
- `PC_STEP`, default 4: sequential PC increment.

- `CLK`, input, 1: sole clock; all state updates on the rising edge.
- `Reset`, input, 1: synchronous, active-high reset.
- `IMemReq`, output, 1: fetch request; held until acknowledged.
- `IMemAddr`, output, `PC_W`: fetch address; stable while `IMemReq` is high and unacknowledged.
- `IMemAck`, input, 1: data valid this cycle; ignored when `IMemReq` is 0.
- `IMemData`, input, `INSTR_W`: instruction word; valid when `IMemAck` is high.
- `Stall`, input, 1: hazard hold request for the IF/ID register.
- `Redirect`, input, 1: taken jmp/jb from execute; flushes the pipeline.
- `RedirectPC`, input, `PC_W`: target address; used as given, with no alignment check.
- `InstrValid`, output, 1: IF/ID holds a live instruction.
- `Instr`, output, `INSTR_W`: IF/ID instruction.
- `OpCode`, output, 6: `Instr[31:26]`, sent to the control unit.
- `InstrPC`, output, `PC_W`: address of `Instr`.

## Operation
- **State machine.** States are FETCH, HOLD and DRAIN.
- **Event priority.** `Reset` > `Redirect` > `Stall`.
- **IF/ID accept condition.** `accept = !Stall || !InstrValid`. A bubble can always be overwritten.
- **FETCH.**
  - `IMemReq` = 1 and `IMemAddr` = PC.
  - On ack with `Redirect`: discard the data, PC ← `RedirectPC`, stay in FETCH.
  - On ack with `accept`: IF/ID ← {1, data, PC}, PC ← PC + `PC_STEP`.
  - On ack without `accept`: skid ← {data, PC}, PC ← PC + `PC_STEP`, go to HOLD.
  - On no ack with `Redirect`: target ← `RedirectPC`, go to DRAIN. The request stays up with the old address, because it cannot be cancelled.
- **HOLD.**
  - `IMemReq` = 0.
  - On `Redirect`: drop the skid entry, PC ← `RedirectPC`, go to FETCH.
  - On `accept`: IF/ID ← skid, go to FETCH.
- **DRAIN.**
  - `IMemReq` = 1 with the old address.
  - A further `Redirect` overwrites target (the last one wins).
  - On ack: discard the data, PC ← target (or `RedirectPC` if `Redirect` is also high this cycle), go to FETCH.
- **IF/ID register.**
  - `Redirect` forces `InstrValid` ← 0 regardless of `Stall`.
  - When `Stall` is high and `InstrValid` is 1: the register holds.
  - When `accept` is high and there is no new word: `InstrValid` ← 0.
- **Arithmetic.** PC increment wraps modulo 2^`PC_W`; 0xFFFFFFFC + 4 = 0x00000000.
- **Reset.**
  - PC ← `RESET_PC`; state ← FETCH.
  - `InstrValid`, `Instr` and `InstrPC` ← 0; skid and target ← 0.
  - `IMemReq` is 0 during any cycle in which `Reset` is high.
  - Reset mid-request abandons the request. Memory is reset by the same signal.

## Timing
- Fetch latency: data acked at edge N appears on `Instr`/`InstrValid` from edge N (registered, visible in cycle N+1).
- The first request is issued in the first cycle after `Reset` deasserts.
- Throughput is one instruction per cycle when `IMemAck` is asserted every cycle.
- Redirect penalty: `InstrValid` is 0 in the cycle after `Redirect`. The target fetch is issued that cycle, or after the drain ack if a request was in flight.
- The skid buffer guarantees that no acked word is lost when `Stall` rises in the ack cycle.
- At most one request is outstanding. `IMemAddr` changes only in cycles after an ack or when `IMemReq` is low.

## Structure
- **Shared package:**
  - state encoding constants `ST_FETCH`, `ST_HOLD`, `ST_DRAIN`;
  - `OPCODE_MSB`/`OPCODE_LSB` = 31/26;
  - opcode constants `OP_JMP` = 6'b100010 and `OP_JB` = 6'b100011 (also used by execute for redirect).
- **Sub-module `if_id_reg`:** the IF/ID register with load/flush/hold controls, reused by later pipeline registers.
- **Top level:** the FSM, PC, target and skid registers stay in `if_stage`.

## Test plan
- **Reset then free-run.** `Reset` for 2 cycles, `RESET_PC` = 0, ack every cycle returning `addr` | 0x04000000 → `InstrPC` = 0, 4, 8… on consecutive cycles, `OpCode` = 6'b000001, no gaps.
- **Stall in the ack cycle.** Data 0x88000010 at PC 0x8 is acked while `Stall` = 1 with IF/ID valid, and stall holds 3 cycles → HOLD state, `IMemReq` = 0, IF/ID unchanged. Data 0x88000010 enters IF/ID the cycle after `Stall` drops, and the next fetch address is 0xC.
- **Redirect with the request pending.** `Redirect`, `RedirectPC` = 0x100 while the ack for 0x20 is delayed 3 cycles → 0x20 is held on `IMemAddr` until ack, its data is discarded, the next `IMemAddr` is 0x100, and `InstrValid` = 0 throughout the drain.
- **Redirect coincident with ack and stall.** `Redirect` = 1, `Stall` = 1, ack = 1 in the same cycle → IF/ID flushed (`InstrValid` = 0), ack data dropped, PC = `RedirectPC`, no HOLD entry.
- **PC wrap.** `RedirectPC` = 0xFFFFFFFC → fetches 0xFFFFFFFC then 0x00000000.
- **Reset mid-HOLD.** Assert `Reset` while in HOLD → the next cycle shows `InstrValid` = 0, PC = `RESET_PC`, and the skid buffer contents are never delivered.
